// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// 1-bit full-adder cell: combinational sum and carry.
module serial_add_ctrl_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: loads operands, drives the full-adder cell LSB-first
// one bit per clock, and presents {cout,sum} over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one operand bit per edge through the cell, WIDTH edges
// DONE  | result held until out_ready
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_co;

   serial_add_ctrl_fa fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (in_valid)        state_nxt = ST_RUN;
            ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE: if (out_ready)       state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
         endcase
      end
   end

   // The edge that leaves RUN still shifts in the MSB sum bit and the final carry.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else if (clr) begin
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            ST_RUN: begin
               sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
               carry  <= fa_co;
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               cnt    <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign busy      = (state == ST_RUN);
   assign out_valid = (state == ST_DONE);
   assign sum       = sum_sr;
   assign cout      = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with WIDTH=8 against an arithmetic reference.
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             ck;
   logic             rst;
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .ck        (ck),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   initial ck = 1'b0;
   always #50 ck = ~ck;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic c);
      return {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
   endfunction

   // Called at a negedge while idle; returns at the first negedge after the accept edge.
   task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic c);
      a        = x;
      b        = y;
      cin      = c;
      in_valid = 1'b1;
      @(posedge ck);
      @(negedge ck);
      in_valid = 1'b0;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      cin      = 1'($urandom);
   endtask

   task automatic wait_result(output int runs, output bit ok);
      runs = 0;
      ok   = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         if (busy) runs++;
         @(negedge ck);
      end
   endtask

   task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic c, input string name);
      int            runs;
      bit            ok;
      logic [WIDTH:0] exp;
      exp = ref_add(x, y, c);
      out_ready = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_idle: in_ready=%b expected 1", name, in_ready);
      end
      start_op(x, y, c);
      wait_result(runs, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_timeout: out_valid=%b expected 1 within bound", name, out_valid);
      end
      checks++;
      if (runs !== WIDTH) begin
         failures++;
         $display("FAIL %s_busy_cycles: got %0d expected %0d", name, runs, WIDTH);
      end
      checks++;
      if ({cout, sum} !== exp) begin
         failures++;
         $display("FAIL %s_result: got cout=%b sum=%h expected cout=%b sum=%h",
                  name, cout, sum, exp[WIDTH], exp[WIDTH-1:0]);
      end
      @(negedge ck);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_release: out_valid=%b in_ready=%b expected 0/1",
                  name, out_valid, in_ready);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
          sum !== '0 || cout !== 1'b0) begin
         failures++;
         $display("FAIL %s: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b expected 1/0/0/00/0",
                  name, in_ready, out_valid, busy, sum, cout);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      check_reset_outputs("reset_immediate");
      repeat (2) begin
         @(negedge ck);
         check_reset_outputs("reset_held");
      end
      rst = 1'b1;
      @(negedge ck);
      check_reset_outputs("reset_released");
   endtask

   task automatic test_basic();
      run_op(8'h3C, 8'h55, 1'b0, "add_3c_55");
      run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
      run_op(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
      run_op(8'h00, 8'h00, 1'b0, "add_zero");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "random");
      end
   endtask

   task automatic test_backpressure();
      int             runs;
      bit             ok;
      logic [WIDTH:0] exp_new;
      out_ready = 1'b0;
      start_op(8'h3C, 8'h55, 1'b0);
      wait_result(runs, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL bp_timeout: out_valid=%b expected 1", out_valid);
      end
      a        = 8'h12;
      b        = 8'h34;
      cin      = 1'b1;
      in_valid = 1'b1;
      exp_new  = ref_add(8'h12, 8'h34, 1'b1);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== 9'h091) begin
            failures++;
            $display("FAIL bp_hold: out_valid=%b in_ready=%b cout=%b sum=%h expected 1/0/0/91",
                     out_valid, in_ready, cout, sum);
         end
         @(negedge ck);
      end
      out_ready = 1'b1;
      @(negedge ck);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_to_idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      @(negedge ck);
      in_valid = 1'b0;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL bp_accept: busy=%b expected 1", busy);
      end
      wait_result(runs, ok);
      checks++;
      if (!ok || {cout, sum} !== exp_new) begin
         failures++;
         $display("FAIL bp_new_result: ok=%b got cout=%b sum=%h expected cout=%b sum=%h",
                  ok, cout, sum, exp_new[WIDTH], exp_new[WIDTH-1:0]);
      end
      @(negedge ck);
   endtask

   task automatic test_clr();
      bit seen;
      out_ready = 1'b1;
      start_op(8'h3C, 8'h55, 1'b0);
      repeat (3) @(negedge ck);
      clr = 1'b1;
      @(negedge ck);
      clr = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL clr_to_idle: in_ready=%b busy=%b expected 1/0", in_ready, busy);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) seen = 1'b1;
         @(negedge ck);
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL clr_no_pulse: out_valid pulse seen=%b expected 0", seen);
      end
      run_op(8'h01, 8'h02, 1'b1, "after_clr");
   endtask

   task automatic test_rst_mid_run();
      out_ready = 1'b1;
      start_op(8'hA7, 8'h5E, 1'b1);
      repeat (4) @(negedge ck);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_busy: busy=%b expected 1", busy);
      end
      rst = 1'b0;
      #1;
      check_reset_outputs("rst_mid_async");
      @(negedge ck);
      check_reset_outputs("rst_mid_held");
      rst = 1'b1;
      @(negedge ck);
      run_op(8'h80, 8'h80, 1'b0, "after_rst");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'b1, "back_to_back");
      end
   endtask

   initial begin
      clr       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      rst       = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_clr();
      test_rst_mid_run();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
